id_ex_stage: RTL and testbench

- ID/EX pipeline stage that sits directly upstream of ALU_and_ALU_control.
- Registers the decoded instruction fields and drives OperandA/OperandB, Funct3/Funct7 and ALUOp into the ALU.
- Resolves EX/MEM and MEM/WB data forwarding for the operands.
- Detects load-use hazards and drives a stall to IF/ID; inserts bubbles on stall and flush.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/fwd_unit.sv | 34 +++
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 tb/tb_id_ex_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared widths, ALUOp encodings and pipeline control types for the ID/EX slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Encodings consumed by ALU_control.
  typedef enum logic [1:0] {
    ALUOP_RTYPE  = 2'b00,
    ALUOP_LDST   = 2'b01,
    ALUOP_BRANCH = 2'b10,
    ALUOP_LUI    = 2'b11
  } aluop_e;

  // Control bits that decide whether a stage slot has any architectural effect.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  // A bubble is a slot with every control bit low.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_unit.sv
// Three-way operand forwarding select: EX/MEM result, else MEM/WB result, else register file data.
// Latency: purely combinational.
// Backpressure: none; always produces a value.
// Ports: rs_addr/rs_data are the held source index and its register-file data;
//        ex_mem_* and mem_wb_* are the two forwarding sources; fwd_data is the selected operand.
module fwd_unit
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   rs_data,
  input  logic              ex_mem_reg_write,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic [XLEN-1:0]   ex_mem_result,
  input  logic              mem_wb_reg_write,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic [XLEN-1:0]   mem_wb_result,
  output logic [XLEN-1:0]   fwd_data
);

  // The younger producer (EX/MEM) wins when both match; x0 is hardwired zero
  // and must never pick up a forwarded value.
  always_comb begin
    fwd_data = rs_data;
    if (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs_addr)) begin
      fwd_data = ex_mem_result;
    end else if (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs_addr)) begin
      fwd_data = mem_wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with operand forwarding and load-use stall detection.
// Latency: one cycle from decode inputs to EX outputs; operands/forwarding are combinational on held state.
// Backpressure: Stall_o holds PC and IF/ID on a load-use hazard while a bubble enters EX; Flush_i overrides the stall.
// Ports: Clk_i/Rst_i clock and synchronous reset; *_i decode fields and control; ExMem*/MemWb* forwarding
//        sources; OperandA_o/OperandB_o/Funct*_o/ALUOp_o to the ALU; StoreData_o, RdAddr_o, control and Valid_o
//        travel down the pipe; Stall_o back to IF/ID.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic              Valid_i,
  input  logic [REG_AW-1:0] Rs1Addr_i,
  input  logic [REG_AW-1:0] Rs2Addr_i,
  input  logic [REG_AW-1:0] RdAddr_i,
  input  logic [XLEN-1:0]   Rs1Data_i,
  input  logic [XLEN-1:0]   Rs2Data_i,
  input  logic [XLEN-1:0]   Imm_i,
  input  logic [2:0]        Funct3_i,
  input  logic [6:0]        Funct7_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              Flush_i,
  input  logic              ExMemRegWrite_i,
  input  logic [REG_AW-1:0] ExMemRd_i,
  input  logic [XLEN-1:0]   ExMemResult_i,
  input  logic              MemWbRegWrite_i,
  input  logic [REG_AW-1:0] MemWbRd_i,
  input  logic [XLEN-1:0]   MemWbResult_i,
  output logic [XLEN-1:0]   OperandA_o,
  output logic [XLEN-1:0]   OperandB_o,
  output logic [2:0]        Funct3_o,
  output logic [6:0]        Funct7_o,
  output logic [1:0]        ALUOp_o,
  output logic [XLEN-1:0]   StoreData_o,
  output logic [REG_AW-1:0] RdAddr_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              Valid_o,
  output logic              Stall_o
);

  typedef struct packed {
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [1:0]        alu_op;
    logic              alu_src;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;
  logic   hazard;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;

  // Load-use: the held load's data is not ready until MEM, so a dependent
  // decode must wait one cycle. rs2 is compared even for immediate forms;
  // an occasional needless stall is cheaper than decoding operand usage here.
  // A bubble held in EX has valid low, so it never raises a hazard.
  always_comb begin
    hazard = stage_q.ctrl.valid && stage_q.ctrl.mem_read && (stage_q.rd != '0) && Valid_i &&
             ((stage_q.rd == Rs1Addr_i) || (stage_q.rd == Rs2Addr_i));
  end

  // A flush kills the decode slot anyway, so there is nothing to hold.
  assign Stall_o = hazard && !Flush_i;

  // Next-state: flush or hazard load an all-zero bubble; an invalid decode
  // slot keeps its fields but cannot have side effects.
  always_comb begin
    stage_d = '0;
    if (!Flush_i && !hazard) begin
      stage_d.ctrl.valid     = Valid_i;
      stage_d.ctrl.reg_write = RegWrite_i;
      stage_d.ctrl.mem_read  = MemRead_i;
      stage_d.ctrl.mem_write = MemWrite_i;
      if (!Valid_i) begin
        stage_d.ctrl = CTRL_BUBBLE;
      end
      stage_d.rd       = RdAddr_i;
      stage_d.rs1      = Rs1Addr_i;
      stage_d.rs2      = Rs2Addr_i;
      stage_d.rs1_data = Rs1Data_i;
      stage_d.rs2_data = Rs2Data_i;
      stage_d.imm      = Imm_i;
      stage_d.funct3   = Funct3_i;
      stage_d.funct7   = Funct7_i;
      stage_d.alu_op   = ALUOp_i;
      stage_d.alu_src  = ALUSrc_i;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr          (stage_q.rs1),
    .rs_data          (stage_q.rs1_data),
    .ex_mem_reg_write (ExMemRegWrite_i),
    .ex_mem_rd        (ExMemRd_i),
    .ex_mem_result    (ExMemResult_i),
    .mem_wb_reg_write (MemWbRegWrite_i),
    .mem_wb_rd        (MemWbRd_i),
    .mem_wb_result    (MemWbResult_i),
    .fwd_data         (fwd1)
  );

  fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr          (stage_q.rs2),
    .rs_data          (stage_q.rs2_data),
    .ex_mem_reg_write (ExMemRegWrite_i),
    .ex_mem_rd        (ExMemRd_i),
    .ex_mem_result    (ExMemResult_i),
    .mem_wb_reg_write (MemWbRegWrite_i),
    .mem_wb_rd        (MemWbRd_i),
    .mem_wb_result    (MemWbResult_i),
    .fwd_data         (fwd2)
  );

  // Stores use the immediate for the address on B, so the rs2 value travels
  // separately; LUI likewise just takes the immediate on B.
  assign OperandA_o  = fwd1;
  assign OperandB_o  = stage_q.alu_src ? stage_q.imm : fwd2;
  assign StoreData_o = fwd2;

  assign Funct3_o   = stage_q.funct3;
  assign Funct7_o   = stage_q.funct7;
  assign ALUOp_o    = stage_q.alu_op;
  assign RdAddr_o   = stage_q.rd;
  assign RegWrite_o = stage_q.ctrl.reg_write;
  assign MemRead_o  = stage_q.ctrl.mem_read;
  assign MemWrite_o = stage_q.ctrl.mem_write;
  assign Valid_o    = stage_q.ctrl.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model expects decode fields one edge later; operands checked combinationally on held state.
// Backpressure: model applies reset > flush > load-use bubble > capture at every edge.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic        Clk_i = 1'b0;
  logic        Rst_i, Valid_i, ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, Flush_i;
  logic [4:0]  Rs1Addr_i, Rs2Addr_i, RdAddr_i, ExMemRd_i, MemWbRd_i;
  logic [31:0] Rs1Data_i, Rs2Data_i, Imm_i, ExMemResult_i, MemWbResult_i;
  logic [2:0]  Funct3_i;
  logic [6:0]  Funct7_i;
  logic [1:0]  ALUOp_i;
  logic        ExMemRegWrite_i, MemWbRegWrite_i;
  logic [31:0] OperandA_o, OperandB_o, StoreData_o;
  logic [2:0]  Funct3_o;
  logic [6:0]  Funct7_o;
  logic [1:0]  ALUOp_o;
  logic [4:0]  RdAddr_o;
  logic        RegWrite_o, MemRead_o, MemWrite_o, Valid_o, Stall_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the instruction held in EX.
  bit          m_valid, m_rw, m_mr, m_mw, m_src;
  int          m_rd, m_rs1, m_rs2;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7;
  logic [1:0]  m_op;

  always #5 Clk_i = ~Clk_i;

  id_ex_stage dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .Valid_i(Valid_i),
    .Rs1Addr_i(Rs1Addr_i), .Rs2Addr_i(Rs2Addr_i), .RdAddr_i(RdAddr_i),
    .Rs1Data_i(Rs1Data_i), .Rs2Data_i(Rs2Data_i), .Imm_i(Imm_i),
    .Funct3_i(Funct3_i), .Funct7_i(Funct7_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i),
    .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .Flush_i(Flush_i),
    .ExMemRegWrite_i(ExMemRegWrite_i), .ExMemRd_i(ExMemRd_i), .ExMemResult_i(ExMemResult_i),
    .MemWbRegWrite_i(MemWbRegWrite_i), .MemWbRd_i(MemWbRd_i), .MemWbResult_i(MemWbResult_i),
    .OperandA_o(OperandA_o), .OperandB_o(OperandB_o), .Funct3_o(Funct3_o), .Funct7_o(Funct7_o),
    .ALUOp_o(ALUOp_o), .StoreData_o(StoreData_o), .RdAddr_o(RdAddr_o), .RegWrite_o(RegWrite_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .Valid_o(Valid_o), .Stall_o(Stall_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Operand value the held source register should see, given the live forwarding buses.
  function automatic logic [31:0] model_operand(input int rs, input logic [31:0] held);
    if (ExMemRegWrite_i && ExMemRd_i != 0 && int'(ExMemRd_i) == rs) return ExMemResult_i;
    if (MemWbRegWrite_i && MemWbRd_i != 0 && int'(MemWbRd_i) == rs) return MemWbResult_i;
    return held;
  endfunction

  function automatic bit model_load_use();
    return m_valid && m_mr && m_rd != 0 && Valid_i &&
           (m_rd == int'(Rs1Addr_i) || m_rd == int'(Rs2Addr_i));
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_src = 0;
    m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    m_d1 = 0; m_d2 = 0; m_imm = 0; m_f3 = 0; m_f7 = 0; m_op = 0;
  endtask

  // Called just after an edge; inputs still hold the values sampled at that edge.
  task automatic model_edge(input bit hz);
    if (Rst_i || Flush_i || hz) begin
      model_clear();
    end else begin
      m_valid = Valid_i;
      m_rw  = Valid_i && RegWrite_i;
      m_mr  = Valid_i && MemRead_i;
      m_mw  = Valid_i && MemWrite_i;
      m_rd  = RdAddr_i;  m_rs1 = Rs1Addr_i; m_rs2 = Rs2Addr_i;
      m_d1  = Rs1Data_i; m_d2 = Rs2Data_i;  m_imm = Imm_i;
      m_f3  = Funct3_i;  m_f7 = Funct7_i;   m_op = ALUOp_i; m_src = ALUSrc_i;
    end
  endtask

  task automatic check_comb();
    logic [31:0] f2;
    f2 = model_operand(m_rs2, m_d2);
    check_eq("stall", 32'(Stall_o), 32'(model_load_use() && !Flush_i));
    check_eq("opA", OperandA_o, model_operand(m_rs1, m_d1));
    check_eq("opB", OperandB_o, m_src ? m_imm : f2);
    check_eq("store_data", StoreData_o, f2);
  endtask

  task automatic check_regs();
    check_eq("valid", 32'(Valid_o), 32'(m_valid));
    check_eq("reg_write", 32'(RegWrite_o), 32'(m_rw));
    check_eq("mem_read", 32'(MemRead_o), 32'(m_mr));
    check_eq("mem_write", 32'(MemWrite_o), 32'(m_mw));
    check_eq("rd", 32'(RdAddr_o), 32'(m_rd));
    check_eq("funct3", 32'(Funct3_o), 32'(m_f3));
    check_eq("funct7", 32'(Funct7_o), 32'(m_f7));
    check_eq("alu_op", 32'(ALUOp_o), 32'(m_op));
  endtask

  // One clock: check live outputs, take the edge, update the model, check again.
  task automatic cycle();
    bit hz;
    #1;
    check_comb();
    hz = model_load_use();
    @(posedge Clk_i);
    model_edge(hz);
    #1;
    check_regs();
    check_comb();
  endtask

  task automatic drive_idle();
    Rst_i = 0; Valid_i = 0; Flush_i = 0;
    Rs1Addr_i = 0; Rs2Addr_i = 0; RdAddr_i = 0;
    Rs1Data_i = 0; Rs2Data_i = 0; Imm_i = 0;
    Funct3_i = 0; Funct7_i = 0; ALUOp_i = ALUOP_RTYPE; ALUSrc_i = 0;
    RegWrite_i = 0; MemRead_i = 0; MemWrite_i = 0;
    ExMemRegWrite_i = 0; ExMemRd_i = 0; ExMemResult_i = 0;
    MemWbRegWrite_i = 0; MemWbRd_i = 0; MemWbResult_i = 0;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    drive_idle();
    Valid_i = 1; MemRead_i = 1; RegWrite_i = 1; RdAddr_i = rd;
    Rs1Addr_i = 5'd1; Rs1Data_i = 32'h100; Imm_i = 32'd8;
    ALUSrc_i = 1; ALUOp_i = ALUOP_LDST; Funct3_i = 3'b010;
  endtask

  initial begin
    drive_idle();
    Rst_i = 1;
    @(posedge Clk_i);
    model_clear();
    #1;
    check_eq("rst_valid", 32'(Valid_o), 0);
    check_eq("rst_reg_write", 32'(RegWrite_o), 0);
    check_eq("rst_stall", 32'(Stall_o), 0);
    check_eq("rst_opA", OperandA_o, 0);
    drive_idle();
    cycle();

    // add x3,x1,x2
    Valid_i = 1; Rs1Addr_i = 1; Rs2Addr_i = 2; RdAddr_i = 3;
    Rs1Data_i = 20; Rs2Data_i = 30; RegWrite_i = 1; ALUOp_i = ALUOP_RTYPE;
    cycle();
    drive_idle();
    #1;
    check_eq("add_opA", OperandA_o, 32'd20);
    check_eq("add_opB", OperandB_o, 32'd30);
    check_eq("add_funct3", 32'(Funct3_o), 0);
    check_eq("add_rd", 32'(RdAddr_o), 32'd3);
    check_eq("add_reg_write", 32'(RegWrite_o), 1);
    cycle();

    // Double-match forwarding on rs1=5
    Valid_i = 1; Rs1Addr_i = 5; Rs1Data_i = 32'h55; RdAddr_i = 6; RegWrite_i = 1;
    cycle();
    drive_idle();
    ExMemRegWrite_i = 1; ExMemRd_i = 5; ExMemResult_i = 111;
    MemWbRegWrite_i = 1; MemWbRd_i = 5; MemWbResult_i = 222;
    #1;
    check_eq("fwd_both", OperandA_o, 32'd111);
    ExMemRegWrite_i = 0;
    #1;
    check_eq("fwd_memwb", OperandA_o, 32'd222);
    drive_idle();
    Valid_i = 1; Rs1Addr_i = 0; Rs1Data_i = 32'h77; RdAddr_i = 6; RegWrite_i = 1;
    cycle();
    drive_idle();
    ExMemRegWrite_i = 1; ExMemRd_i = 0; ExMemResult_i = 111;
    MemWbRegWrite_i = 1; MemWbRd_i = 0; MemWbResult_i = 222;
    #1;
    check_eq("fwd_x0", OperandA_o, 32'h77);
    drive_idle();

    // Load-use: lw x7 then add x8,x1,x7
    drive_load(5'd7);
    cycle();
    drive_idle();
    Valid_i = 1; Rs1Addr_i = 1; Rs2Addr_i = 7; RdAddr_i = 8; RegWrite_i = 1;
    #1;
    check_eq("lu_stall", 32'(Stall_o), 1);
    cycle();
    check_eq("lu_bubble_valid", 32'(Valid_o), 0);
    check_eq("lu_bubble_rw", 32'(RegWrite_o), 0);
    check_eq("lu_bubble_stall", 32'(Stall_o), 0);
    cycle();
    check_eq("lu_capture_valid", 32'(Valid_o), 1);
    check_eq("lu_capture_rd", 32'(RdAddr_o), 32'd8);

    // Flush overriding a load-use hazard
    drive_load(5'd7);
    cycle();
    drive_idle();
    Valid_i = 1; Rs1Addr_i = 7; MemWrite_i = 1; Flush_i = 1;
    #1;
    check_eq("flush_stall", 32'(Stall_o), 0);
    cycle();
    check_eq("flush_valid", 32'(Valid_o), 0);
    check_eq("flush_mem_write", 32'(MemWrite_o), 0);

    // sw with immediate -4 and rs2 forwarded from MEM/WB
    drive_idle();
    Valid_i = 1; Rs1Addr_i = 2; Rs2Addr_i = 9; Rs2Data_i = 32'h1234;
    ALUSrc_i = 1; Imm_i = 32'hFFFF_FFFC; MemWrite_i = 1; ALUOp_i = ALUOP_LDST; Funct3_i = 3'b010;
    cycle();
    drive_idle();
    MemWbRegWrite_i = 1; MemWbRd_i = 9; MemWbResult_i = 32'hDEAD_BEEF;
    #1;
    check_eq("sw_opB", OperandB_o, 32'hFFFF_FFFC);
    check_eq("sw_store_data", StoreData_o, 32'hDEAD_BEEF);
    drive_idle();

    // Reset mid-stream discards a held load
    drive_load(5'd7);
    cycle();
    Rst_i = 1;
    cycle();
    check_eq("midrst_valid", 32'(Valid_o), 0);
    check_eq("midrst_mem_read", 32'(MemRead_o), 0);

    // Randomized traffic; small register range to provoke matches.
    for (int i = 0; i < 600; i++) begin
      Rst_i      = ($urandom_range(0, 49) == 0);
      Flush_i    = ($urandom_range(0, 9) == 0);
      Valid_i    = ($urandom_range(0, 7) != 0);
      Rs1Addr_i  = 5'($urandom_range(0, 7));
      Rs2Addr_i  = 5'($urandom_range(0, 7));
      RdAddr_i   = 5'($urandom_range(0, 7));
      Rs1Data_i  = $urandom;
      Rs2Data_i  = $urandom;
      Imm_i      = $urandom;
      Funct3_i   = 3'($urandom);
      Funct7_i   = 7'($urandom);
      ALUOp_i    = 2'($urandom);
      ALUSrc_i   = 1'($urandom);
      RegWrite_i = 1'($urandom);
      MemRead_i  = ($urandom_range(0, 2) == 0);
      MemWrite_i = 1'($urandom);
      ExMemRegWrite_i = 1'($urandom);
      ExMemRd_i       = 5'($urandom_range(0, 7));
      ExMemResult_i   = $urandom;
      MemWbRegWrite_i = 1'($urandom);
      MemWbRd_i       = 5'($urandom_range(0, 7));
      MemWbResult_i   = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
